// File: rtl/acumulador_sumas_pkg.sv
// Shared types and default widths for the block accumulator that follows sumador_8bits.
package acumulador_pkg;

    typedef enum logic {ACUM, SALIDA} estado_t;

    localparam int ANCHO_SUMA = 8;
    localparam int ANCHO_ACC  = 12;

endpackage

// File: rtl/acumulador_sumas_if.sv
// Input-sample and output-total handshakes of acumulador_sumas.
// A transfer happens on a rising edge where valido & ready are both high; a producer holds data until then.
interface acumulador_if #(
    parameter int ANCHO_SUMA = acumulador_pkg::ANCHO_SUMA,
    parameter int ANCHO_ACC  = acumulador_pkg::ANCHO_ACC
);
    logic                  in_valido;
    logic                  in_ready;
    logic [ANCHO_SUMA-1:0] in_suma;
    logic                  out_valido;
    logic                  out_ready;
    logic [ANCHO_ACC-1:0]  out_total;
    logic                  out_desborde;

    modport master (
        output in_valido, in_suma, out_ready,
        input  in_ready, out_valido, out_total, out_desborde
    );

    modport slave (
        input  in_valido, in_suma, out_ready,
        output in_ready, out_valido, out_total, out_desborde
    );
endinterface

// File: rtl/acumulador_sumas_contador.sv
// Modulo-N_MUESTRAS sample counter; fin_o flags the sample that closes a block.
module contador_modulo #(
    parameter int N_MUESTRAS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic fin_o
);
    localparam int CW = (N_MUESTRAS > 1) ? $clog2(N_MUESTRAS) : 1;

    logic [CW-1:0] cuenta_q, cuenta_d;

    assign fin_o = (cuenta_q == CW'(N_MUESTRAS - 1));

    always_comb begin
        cuenta_d = cuenta_q;
        if (clr_i) begin
            cuenta_d = '0;
        end else if (en_i) begin
            cuenta_d = fin_o ? '0 : cuenta_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end
endmodule

// File: rtl/acumulador_sumas.sv
// Accumulates N_MUESTRAS adder results per block and presents the wrapped total plus a sticky wrap flag.
module acumulador_sumas
    import acumulador_pkg::*;
#(
    parameter int ANCHO_SUMA = acumulador_pkg::ANCHO_SUMA,
    parameter int ANCHO_ACC  = acumulador_pkg::ANCHO_ACC,
    parameter int N_MUESTRAS = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    borrar,
    acumulador_if.slave bus,
    output estado_t estado_o
);
    localparam int W = ANCHO_ACC + 1;

    estado_t              estado_q, estado_d;
    logic [ANCHO_ACC-1:0] acum_q, acum_d;
    logic                 desb_q, desb_d;
    logic [ANCHO_ACC-1:0] total_q, total_d;
    logic                 out_desb_q, out_desb_d;
    logic [W-1:0]         nuevo;
    logic                 acepta;
    logic                 fin;

    // Clear cycles never accept, so a producer's sample survives rst/borrar.
    assign bus.in_ready     = (estado_q == ACUM) && !rst && !borrar;
    assign acepta           = bus.in_valido && bus.in_ready;
    assign nuevo            = {1'b0, acum_q} + W'(bus.in_suma);
    assign bus.out_valido   = (estado_q == SALIDA);
    assign bus.out_total    = total_q;
    assign bus.out_desborde = out_desb_q;
    assign estado_o         = estado_q;

    contador_modulo #(.N_MUESTRAS(N_MUESTRAS)) u_contador (
        .clk   (clk),
        .rst   (rst),
        .clr_i (borrar),
        .en_i  (acepta),
        .fin_o (fin)
    );

    always_comb begin
        estado_d   = estado_q;
        acum_d     = acum_q;
        desb_d     = desb_q;
        total_d    = total_q;
        out_desb_d = out_desb_q;
        if (borrar) begin
            estado_d   = ACUM;
            acum_d     = '0;
            desb_d     = 1'b0;
            total_d    = '0;
            out_desb_d = 1'b0;
        end else begin
            case (estado_q)
                ACUM: begin
                    if (acepta) begin
                        acum_d = nuevo[ANCHO_ACC-1:0];
                        desb_d = desb_q | nuevo[ANCHO_ACC];
                        if (fin) begin
                            estado_d   = SALIDA;
                            total_d    = nuevo[ANCHO_ACC-1:0];
                            out_desb_d = desb_q | nuevo[ANCHO_ACC];
                        end
                    end
                end
                SALIDA: begin
                    if (bus.out_ready) begin
                        estado_d = ACUM;
                        acum_d   = '0;
                        desb_d   = 1'b0;
                    end
                end
                default: estado_d = ACUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= ACUM;
            acum_q     <= '0;
            desb_q     <= 1'b0;
            total_q    <= '0;
            out_desb_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            acum_q     <= acum_d;
            desb_q     <= desb_d;
            total_q    <= total_d;
            out_desb_q <= out_desb_d;
        end
    end
endmodule

// File: tb/tb_acumulador_sumas.sv
// Bench for acumulador_sumas: a default-size block (4 samples) and a 20-sample block that can wrap.
module tb_acumulador_sumas;
    import acumulador_pkg::*;

    localparam int NA = 4;
    localparam int NB = 20;

    logic clk = 1'b0;
    logic rst;
    logic borrar_a, borrar_b;
    estado_t est_a, est_b;

    acumulador_if #(.ANCHO_SUMA(8), .ANCHO_ACC(12)) if_a ();
    acumulador_if #(.ANCHO_SUMA(8), .ANCHO_ACC(12)) if_b ();

    acumulador_sumas #(.ANCHO_SUMA(8), .ANCHO_ACC(12), .N_MUESTRAS(NA)) dut_a (
        .clk(clk), .rst(rst), .borrar(borrar_a), .bus(if_a), .estado_o(est_a));
    acumulador_sumas #(.ANCHO_SUMA(8), .ANCHO_ACC(12), .N_MUESTRAS(NB)) dut_b (
        .clk(clk), .rst(rst), .borrar(borrar_b), .bus(if_b), .estado_o(est_b));

    // clock
    always #5 clk = ~clk;

    // scoreboard state: {desborde, total}
    logic [12:0] exp_a[$];
    logic [12:0] exp_b[$];
    int total = 0;
    int bad = 0;
    int part_a = 0, cnt_a = 0;
    int part_b = 0, cnt_b = 0;
    bit rand_rdy = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: a block's result is the plain integer sum of its samples
    task automatic model_accept(input int sel, input int val);
        int s;
        if (sel == 0) begin
            part_a += val; cnt_a++;
            if (cnt_a == NA) begin
                s = part_a;
                exp_a.push_back({1'(s >= 4096), 12'(s % 4096)});
                part_a = 0; cnt_a = 0;
            end
        end else begin
            part_b += val; cnt_b++;
            if (cnt_b == NB) begin
                s = part_b;
                exp_b.push_back({1'(s >= 4096), 12'(s % 4096)});
                part_b = 0; cnt_b = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        if (rand_rdy) if_a.out_ready = 1'($urandom_range(0, 1));
    endtask

    // driver: offers one sample and waits (bounded) for the handshake
    task automatic send(input int sel, input int val);
        int tries = 0;
        logic rdy;
        if (sel == 0) begin if_a.in_valido = 1'b1; if_a.in_suma = 8'(val); end
        else          begin if_b.in_valido = 1'b1; if_b.in_suma = 8'(val); end
        forever begin
            @(negedge clk);
            rdy = (sel == 0) ? if_a.in_ready : if_b.in_ready;
            step();
            if (rdy) break;
            tries++;
            if (tries > 200) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        if (sel == 0) if_a.in_valido = 1'b0; else if_b.in_valido = 1'b0;
        if (rdy) model_accept(sel, val);
    endtask

    // monitor: compares every taken output against the queue head
    initial begin
        logic [12:0] e;
        forever begin
            @(negedge clk);
            if (!rst && if_a.out_valido && if_a.out_ready) begin
                if (exp_a.size() == 0) check("out_a_unexpected", 1, 0);
                else begin
                    e = exp_a.pop_front();
                    check("out_a_total", 32'(if_a.out_total), 32'(e[11:0]));
                    check("out_a_desborde", 32'(if_a.out_desborde), 32'(e[12]));
                end
            end
            if (!rst && if_b.out_valido && if_b.out_ready) begin
                if (exp_b.size() == 0) check("out_b_unexpected", 1, 0);
                else begin
                    e = exp_b.pop_front();
                    check("out_b_total", 32'(if_b.out_total), 32'(e[11:0]));
                    check("out_b_desborde", 32'(if_b.out_desborde), 32'(e[12]));
                end
            end
        end
    end

    initial begin
        int s2[4];
        rst = 1'b1; borrar_a = 1'b0; borrar_b = 1'b0;
        if_a.in_valido = 1'b1; if_a.in_suma = 8'd7; if_a.out_ready = 1'b1;
        if_b.in_valido = 1'b1; if_b.in_suma = 8'd7; if_b.out_ready = 1'b1;

        // 1. reset with in_valido high
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready_a", 32'(if_a.in_ready), 0);
            check("rst_out_valido_a", 32'(if_a.out_valido), 0);
            check("rst_in_ready_b", 32'(if_b.in_ready), 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; if_a.in_valido = 1'b0; if_b.in_valido = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(if_a.in_ready), 1);
        check("post_rst_total", 32'(if_a.out_total), 0);
        check("post_rst_desborde", 32'(if_a.out_desborde), 0);
        check("post_rst_out_valido", 32'(if_a.out_valido), 0);
        step();

        // 2. basic block, back to back
        s2 = '{3, 14, 20, 4};
        foreach (s2[i]) send(0, s2[i]);
        @(negedge clk);
        check("blk_out_valido", 32'(if_a.out_valido), 1);
        check("blk_total", 32'(if_a.out_total), 41);
        check("blk_in_ready", 32'(if_a.in_ready), 0);
        step();
        @(negedge clk);
        check("blk_valido_one_cycle", 32'(if_a.out_valido), 0);
        step();

        // 3. carry-bearing samples with backpressure
        if_a.out_ready = 1'b0;
        s2 = '{216, 173, 115, 42};
        foreach (s2[i]) send(0, s2[i]);
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valido", 32'(if_a.out_valido), 1);
            check("bp_total_hold", 32'(if_a.out_total), 546);
            check("bp_in_ready", 32'(if_a.in_ready), 0);
            step();
        end
        if_a.out_ready = 1'b1;
        step();
        @(negedge clk);
        check("bp_in_ready_back", 32'(if_a.in_ready), 1);
        step();

        // 4. overflow on the 20-sample instance, then the flag must clear
        repeat (NB) send(1, 255);
        @(negedge clk);
        check("ovf_total", 32'(if_b.out_total), 1004);
        check("ovf_desborde", 32'(if_b.out_desborde), 1);
        step();
        repeat (NB) send(1, 1);
        @(negedge clk);
        check("ovf2_total", 32'(if_b.out_total), 20);
        check("ovf2_desborde", 32'(if_b.out_desborde), 0);
        step();

        // 5. borrar mid-block discards partial sum and consumes nothing
        send(0, 2); send(0, 1);
        borrar_a = 1'b1; if_a.in_valido = 1'b1; if_a.in_suma = 8'd99;
        @(negedge clk);
        check("borrar_in_ready", 32'(if_a.in_ready), 0);
        step();
        borrar_a = 1'b0; if_a.in_valido = 1'b0;
        part_a = 0; cnt_a = 0;
        s2 = '{10, 10, 2, 2};
        foreach (s2[i]) send(0, s2[i]);
        @(negedge clk);
        check("borrar_total", 32'(if_a.out_total), 24);
        step();

        // 6. gapped input, no early out_valido
        s2 = '{15, 15, 100, 15};
        foreach (s2[i]) begin
            send(0, s2[i]);
            if (i < 3) repeat (3) begin
                @(negedge clk);
                check("gap_no_valido", 32'(if_a.out_valido), 0);
                step();
            end
        end
        @(negedge clk);
        check("gap_total", 32'(if_a.out_total), 145);
        step();

        // random phase: random samples, gaps and consumer backpressure
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            send(0, int'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) step();
        end
        for (int i = 0; i < 30; i++) begin
            send(1, int'($urandom_range(150, 255)));
        end
        rand_rdy = 0;
        if_a.out_ready = 1'b1; if_b.out_ready = 1'b1;

        // drain
        for (int i = 0; i < 60; i++) begin
            if (exp_a.size() == 0 && exp_b.size() == 0) break;
            step();
        end
        step();
        check("drain_a_empty", 32'(exp_a.size()), 0);
        check("drain_b_empty", 32'(exp_b.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
